mesm6_mem_ctrl: RTL and testbench

Memory responder for the MESM-6 core's two request buses. It serves the instruction-fetch bus (ibus) and the data read/write bus (dbus) from one single-port synchronous RAM of 32K x 48-bit words.
- Serialises requests that arrive together.
- Raises the done flags of all requests in one batch together, so the core's combined busy signal drops in a single cycle.
- Inserts a guard cycle after each batch, because the core's microinstruction register lags its microcode PC by one cycle and still shows the old request.

---
 rtl/mesm6_mem_pkg.sv | 22 ++
 rtl/mesm6_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mesm6_mem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesm6_mem_pkg.sv
// Shared types and constants for the MESM-6 memory responder.
package mesm6_mem_pkg;

    // Width of the per-access wait-state counter (WAIT_STATES is 0..15)
    localparam int WAIT_CNT_BITS = 4;

    // Bit positions inside a port mask
    localparam int PORT_DBUS = 0;
    localparam int PORT_IBUS = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
        COMPLETE = 3'd3,
        GUARD    = 3'd4
    } state_e;

    // Bit 0 = dbus, bit 1 = ibus
    typedef logic [1:0] port_mask_t;

endpackage

// File: rtl/mesm6_mem_ctrl.sv
// Memory responder serving the MESM-6 ibus and dbus from one single-port RAM.
// Requests latched together form a batch; the batch finishes with all done
// flags raised in one cycle, followed by a guard cycle that ignores requests.
import mesm6_mem_pkg::*;

module mesm6_mem_ctrl #(
    parameter int AW          = 15,
    parameter int DW          = 48,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ibus_fetch,
    input  logic [AW-1:0] ibus_addr,
    output logic [DW-1:0] ibus_input,
    output logic          ibus_done,
    input  logic          dbus_read,
    input  logic          dbus_write,
    input  logic [AW-1:0] dbus_addr,
    input  logic [DW-1:0] dbus_output,
    output logic [DW-1:0] dbus_input,
    output logic          dbus_done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          bus_error
);

    localparam logic [WAIT_CNT_BITS-1:0] WAIT_LOAD = WAIT_CNT_BITS'(WAIT_STATES);

    state_e                   state_q, state_d;
    port_mask_t               pend_q, pend_d;
    port_mask_t               latch_q, latch_d;
    port_mask_t               served_mask;
    logic [AW-1:0]            iaddr_q, iaddr_d;
    logic [AW-1:0]            daddr_q, daddr_d;
    logic [DW-1:0]            wdata_q, wdata_d;
    logic                     is_write_q, is_write_d;
    logic                     rw_clash_q, rw_clash_d;
    logic                     serve_dbus_q, serve_dbus_d;
    logic [WAIT_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [DW-1:0]            ibus_input_q, ibus_input_d;
    logic [DW-1:0]            dbus_input_q, dbus_input_d;

    // State register and datapath flops; synchronous reset aborts any batch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            latch_q      <= '0;
            iaddr_q      <= '0;
            daddr_q      <= '0;
            wdata_q      <= '0;
            is_write_q   <= 1'b0;
            rw_clash_q   <= 1'b0;
            serve_dbus_q <= 1'b0;
            cnt_q        <= '0;
            ibus_input_q <= '0;
            dbus_input_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            latch_q      <= latch_d;
            iaddr_q      <= iaddr_d;
            daddr_q      <= daddr_d;
            wdata_q      <= wdata_d;
            is_write_q   <= is_write_d;
            rw_clash_q   <= rw_clash_d;
            serve_dbus_q <= serve_dbus_d;
            cnt_q        <= cnt_d;
            ibus_input_q <= ibus_input_d;
            dbus_input_q <= dbus_input_d;
        end
    end

    // Next state plus batch latching, port selection, wait counting and read capture
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        latch_d      = latch_q;
        iaddr_d      = iaddr_q;
        daddr_d      = daddr_q;
        wdata_d      = wdata_q;
        is_write_d   = is_write_q;
        rw_clash_d   = rw_clash_q;
        serve_dbus_d = serve_dbus_q;
        cnt_d        = cnt_q;
        ibus_input_d = ibus_input_q;
        dbus_input_d = dbus_input_q;
        served_mask  = '0;
        case (state_q)
            IDLE: begin
                pend_d     = {ibus_fetch, dbus_read | dbus_write};
                latch_d    = {ibus_fetch, dbus_read | dbus_write};
                iaddr_d    = ibus_addr;
                daddr_d    = dbus_addr;
                wdata_d    = dbus_output;
                is_write_d = dbus_write;
                rw_clash_d = dbus_read & dbus_write;
                if (ibus_fetch || dbus_read || dbus_write) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                serve_dbus_d = pend_q[PORT_DBUS];
                cnt_d        = WAIT_LOAD;
                state_d      = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    served_mask[PORT_DBUS] = serve_dbus_q;
                    served_mask[PORT_IBUS] = !serve_dbus_q;
                    pend_d = pend_q & ~served_mask;
                    if (serve_dbus_q) begin
                        if (!is_write_q) begin
                            dbus_input_d = ram_rdata;
                        end
                    end else begin
                        ibus_input_d = ram_rdata;
                    end
                    state_d = (|(pend_q & ~served_mask)) ? ISSUE : COMPLETE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COMPLETE: begin
                state_d = GUARD;
            end
            GUARD: begin
                latch_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: RAM strobe only in ISSUE, done flags of the whole batch in COMPLETE
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        bus_error = 1'b0;
        if (state_q == ISSUE) begin
            ram_en = 1'b1;
            if (pend_q[PORT_DBUS]) begin
                ram_addr  = daddr_q;
                ram_we    = is_write_q;
                bus_error = rw_clash_q;
                if (is_write_q) begin
                    ram_wdata = wdata_q;
                end
            end else begin
                ram_addr = iaddr_q;
            end
        end
        ibus_done = (state_q == COMPLETE) && latch_q[PORT_IBUS];
        dbus_done = (state_q == COMPLETE) && latch_q[PORT_DBUS];
    end

    assign ibus_input = ibus_input_q;
    assign dbus_input = dbus_input_q;

endmodule

// File: tb/tb_mesm6_mem_ctrl.sv
// Self-checking bench for mesm6_mem_ctrl: two instances (0 and 2 wait states),
// each with its own behavioural RAM, driven from a vector table, random
// transactions and hand-written corner sequences.
module tb_mesm6_mem_ctrl;
    import mesm6_mem_pkg::*;

    localparam int AW  = 15;
    localparam int DW  = 48;
    localparam int WS0 = 0;
    localparam int WS1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset       [2];
    logic          ibus_fetch  [2];
    logic [AW-1:0] ibus_addr   [2];
    logic          dbus_read   [2];
    logic          dbus_write  [2];
    logic [AW-1:0] dbus_addr   [2];
    logic [DW-1:0] dbus_output [2];
    logic [DW-1:0] ram_rdata   [2];
    wire  [DW-1:0] ibus_input_w[2];
    wire           ibus_done_w [2];
    wire  [DW-1:0] dbus_input_w[2];
    wire           dbus_done_w [2];
    wire           ram_en_w    [2];
    wire           ram_we_w    [2];
    wire  [AW-1:0] ram_addr_w  [2];
    wire  [DW-1:0] ram_wdata_w [2];
    wire           bus_error_w [2];

    int total = 0;
    int bad   = 0;

    mesm6_mem_ctrl #(.AW(AW), .DW(DW), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .ibus_fetch(ibus_fetch[0]), .ibus_addr(ibus_addr[0]),
        .ibus_input(ibus_input_w[0]), .ibus_done(ibus_done_w[0]),
        .dbus_read(dbus_read[0]), .dbus_write(dbus_write[0]),
        .dbus_addr(dbus_addr[0]), .dbus_output(dbus_output[0]),
        .dbus_input(dbus_input_w[0]), .dbus_done(dbus_done_w[0]),
        .ram_en(ram_en_w[0]), .ram_we(ram_we_w[0]), .ram_addr(ram_addr_w[0]),
        .ram_wdata(ram_wdata_w[0]), .ram_rdata(ram_rdata[0]),
        .bus_error(bus_error_w[0])
    );

    mesm6_mem_ctrl #(.AW(AW), .DW(DW), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .ibus_fetch(ibus_fetch[1]), .ibus_addr(ibus_addr[1]),
        .ibus_input(ibus_input_w[1]), .ibus_done(ibus_done_w[1]),
        .dbus_read(dbus_read[1]), .dbus_write(dbus_write[1]),
        .dbus_addr(dbus_addr[1]), .dbus_output(dbus_output[1]),
        .dbus_input(dbus_input_w[1]), .dbus_done(dbus_done_w[1]),
        .ram_en(ram_en_w[1]), .ram_we(ram_we_w[1]), .ram_addr(ram_addr_w[1]),
        .ram_wdata(ram_wdata_w[1]), .ram_rdata(ram_rdata[1]),
        .bus_error(bus_error_w[1])
    );

    // Behavioural single-port RAMs: read data appears the cycle after ram_en
    logic [DW-1:0] mem [2][32768];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_en_w[d]) begin
                if (ram_we_w[d]) mem[d][ram_addr_w[d]] = ram_wdata_w[d];
                else             ram_rdata[d] <= mem[d][ram_addr_w[d]];
            end
        end
    end

    // Reference model: memory contents and last delivered read data per port
    logic [DW-1:0] ref_mem [2][32768];
    logic [DW-1:0] ref_i [2];
    logic [DW-1:0] ref_d [2];

    typedef struct {
        int            dut;
        logic          f, rd, wr;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] wd;
        int            exp_done;
        logic [DW-1:0] exp_i, exp_d;
        logic          exp_err;
    } vec_t;

    vec_t vecs [8];
    logic [AW-1:0] pool [8];

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // The write of a batch lands before the fetch is served (dbus goes first)
    task automatic model_txn(input int d, input logic f, rd, wr, input logic [AW-1:0] ia, da, input logic [DW-1:0] wd);
        if (wr) ref_mem[d][da] = wd;
        else if (rd) ref_d[d] = ref_mem[d][da];
        if (f) ref_i[d] = ref_mem[d][ia];
    endtask

    // One batch: drive requests, follow the cycle-by-cycle protocol, release after done
    task automatic apply_stimulus(input int d, input logic f, rd, wr, input logic [AW-1:0] ia, da,
                                  input logic [DW-1:0] wd, input int exp_done,
                                  input logic [DW-1:0] exp_i, exp_d, input logic exp_err);
        int   n, step, k;
        logic dreq, en_exp, srv_d;
        dreq = rd | wr;
        n    = int'(f) + int'(dreq);
        step = ws_of(d) + 2;
        @(posedge clk); #1;
        ibus_fetch[d] = f;  ibus_addr[d] = ia;
        dbus_read[d]  = rd; dbus_write[d] = wr; dbus_addr[d] = da; dbus_output[d] = wd;
        for (int c = 0; c <= exp_done + 2; c++) begin
            @(negedge clk);
            en_exp = 1'b0;
            srv_d  = 1'b0;
            k      = -1;
            if (c >= 1 && ((c - 1) % step) == 0 && ((c - 1) / step) < n) begin
                en_exp = 1'b1;
                k      = (c - 1) / step;
                srv_d  = dreq && (k == 0);
            end
            check_output("ram_en", ram_en_w[d], en_exp);
            check_output("bus_error", bus_error_w[d], en_exp && srv_d && exp_err);
            if (en_exp) begin
                check_output("ram_addr", ram_addr_w[d], srv_d ? da : ia);
                check_output("ram_we", ram_we_w[d], srv_d && wr);
                if (srv_d && wr) check_output("ram_wdata", ram_wdata_w[d], wd);
            end
            check_output("ibus_done", ibus_done_w[d], f && (c == exp_done));
            check_output("dbus_done", dbus_done_w[d], dreq && (c == exp_done));
            if (c == exp_done) begin
                if (f)    check_output("ibus_input", ibus_input_w[d], exp_i);
                if (dreq) check_output("dbus_input", dbus_input_w[d], exp_d);
                @(posedge clk); #1;
                ibus_fetch[d] = 1'b0; dbus_read[d] = 1'b0; dbus_write[d] = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            sel, op;
        logic          f, rd, wr;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] wd;

        for (int a = 0; a < 32768; a++) begin
            for (int d = 0; d < 2; d++) begin
                mem[d][a]     = 48'hC0DE_0000_0000 | 48'(a);
                ref_mem[d][a] = 48'hC0DE_0000_0000 | 48'(a);
            end
        end
        for (int d = 0; d < 2; d++) begin
            mem[d][15'h0002] = 48'hAAAA5555AAAA; ref_mem[d][15'h0002] = 48'hAAAA5555AAAA;
            mem[d][15'h7FFF] = 48'h000000000001; ref_mem[d][15'h7FFF] = 48'h000000000001;
            ref_i[d] = '0; ref_d[d] = '0;
            reset[d] = 1'b1; ibus_fetch[d] = 1'b0; ibus_addr[d] = '0;
            dbus_read[d] = 1'b0; dbus_write[d] = 1'b0; dbus_addr[d] = '0; dbus_output[d] = '0;
        end

        vecs[0] = '{0, 1'b0, 1'b0, 1'b1, 15'h0000, 15'h0010, 48'h123456789ABC, 3, 48'h0, 48'h0, 1'b0};
        vecs[1] = '{0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0010, 48'h0, 3, 48'h0, 48'h123456789ABC, 1'b0};
        vecs[2] = '{0, 1'b1, 1'b1, 1'b0, 15'h0002, 15'h7FFF, 48'h0, 5, 48'hAAAA5555AAAA, 48'h000000000001, 1'b0};
        vecs[3] = '{1, 1'b1, 1'b0, 1'b0, 15'h0002, 15'h0000, 48'h0, 5, 48'hAAAA5555AAAA, 48'h0, 1'b0};
        vecs[4] = '{0, 1'b0, 1'b1, 1'b1, 15'h0000, 15'h0100, 48'hDEADBEEF0001, 3, 48'h0, 48'h000000000001, 1'b1};
        vecs[5] = '{0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h0100, 48'h0, 3, 48'h0, 48'hDEADBEEF0001, 1'b0};
        vecs[6] = '{0, 1'b1, 1'b0, 1'b0, 15'h7FFF, 15'h0000, 48'h0, 3, 48'h000000000001, 48'h0, 1'b0};
        vecs[7] = '{1, 1'b1, 1'b0, 1'b1, 15'h0003, 15'h0003, 48'h0F0F0F0F0F0F, 9, 48'h0F0F0F0F0F0F, 48'h0, 1'b0};
        pool = '{15'h0000, 15'h0001, 15'h0002, 15'h0003, 15'h0010, 15'h0100, 15'h4000, 15'h7FFF};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_output("rst_ram_en", ram_en_w[d], 1'b0);
            check_output("rst_ram_we", ram_we_w[d], 1'b0);
            check_output("rst_ibus_done", ibus_done_w[d], 1'b0);
            check_output("rst_dbus_done", dbus_done_w[d], 1'b0);
            check_output("rst_bus_error", bus_error_w[d], 1'b0);
            check_output("rst_ibus_input", ibus_input_w[d], '0);
            check_output("rst_dbus_input", dbus_input_w[d], '0);
            check_output("rst_ram_addr", ram_addr_w[d], '0);
            check_output("rst_ram_wdata", ram_wdata_w[d], '0);
        end
        check_output("rst_state0", 48'(u_dut0.state_q), 48'(IDLE));
        check_output("rst_state1", 48'(u_dut1.state_q), 48'(IDLE));
        @(posedge clk); #1;
        reset[0] = 1'b0; reset[1] = 1'b0;

        // Directed vectors
        for (int v = 0; v < 8; v++) begin
            model_txn(vecs[v].dut, vecs[v].f, vecs[v].rd, vecs[v].wr, vecs[v].ia, vecs[v].da, vecs[v].wd);
            apply_stimulus(vecs[v].dut, vecs[v].f, vecs[v].rd, vecs[v].wr, vecs[v].ia, vecs[v].da,
                           vecs[v].wd, vecs[v].exp_done, vecs[v].exp_i, vecs[v].exp_d, vecs[v].exp_err);
        end

        // Random batches checked against the reference model
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 25; t++) begin
                sel = int'($urandom_range(1, 3));
                op  = int'($urandom_range(0, 2));
                f   = sel[1];
                rd  = sel[0] && (op != 1);
                wr  = sel[0] && (op != 0);
                ia  = pool[$urandom_range(0, 7)];
                da  = pool[$urandom_range(0, 7)];
                wd  = {16'($urandom), 32'($urandom)};
                model_txn(d, f, rd, wr, ia, da, wd);
                apply_stimulus(d, f, rd, wr, ia, da, wd,
                               1 + (int'(f) + int'(rd | wr)) * (ws_of(d) + 2),
                               ref_i[d], ref_d[d], rd & wr);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        // Fetch held through the guard cycle into the next IDLE: exactly one extra transaction
        @(posedge clk); #1;
        ibus_fetch[0] = 1'b1; ibus_addr[0] = 15'h0005;
        model_txn(0, 1'b1, 1'b0, 1'b0, 15'h0005, 15'h0000, 48'h0);
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            check_output("held_ram_en", ram_en_w[0], (c == 1) || (c == 6));
            check_output("held_ibus_done", ibus_done_w[0], (c == 3) || (c == 8));
            if (c == 3 || c == 8) check_output("held_ibus_input", ibus_input_w[0], ref_i[0]);
            if (c == 5) begin
                @(posedge clk); #1;
                ibus_fetch[0] = 1'b0;
            end
        end

        // Reset during WAIT on the two-wait-state instance aborts the batch
        @(posedge clk); #1;
        dbus_read[1] = 1'b1; dbus_addr[1] = 15'h0010;
        @(negedge clk);
        @(negedge clk);
        check_output("abort_ram_en_issue", ram_en_w[1], 1'b1);
        @(posedge clk); #1;
        reset[1] = 1'b1; dbus_read[1] = 1'b0;
        @(negedge clk);
        check_output("abort_in_wait", 48'(u_dut1.state_q), 48'(WAIT));
        @(posedge clk); #1;
        reset[1] = 1'b0;
        ref_i[1] = '0; ref_d[1] = '0;
        @(negedge clk);
        check_output("abort_state", 48'(u_dut1.state_q), 48'(IDLE));
        check_output("abort_ibus_input", ibus_input_w[1], ref_i[1]);
        check_output("abort_dbus_input", dbus_input_w[1], ref_d[1]);
        check_output("abort_ram_addr", ram_addr_w[1], '0);
        check_output("abort_ram_wdata", ram_wdata_w[1], '0);
        check_output("abort_ram_we", ram_we_w[1], 1'b0);
        check_output("abort_bus_error", bus_error_w[1], 1'b0);
        for (int c = 0; c < 8; c++) begin
            check_output("abort_ram_en", ram_en_w[1], 1'b0);
            check_output("abort_ibus_done", ibus_done_w[1], 1'b0);
            check_output("abort_dbus_done", dbus_done_w[1], 1'b0);
            @(negedge clk);
        end

        // The aborted instance still serves a fresh read afterwards
        model_txn(1, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h4000, 48'h0);
        apply_stimulus(1, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h4000, 48'h0, 5, ref_i[1], ref_d[1], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
